cluster_frame_serializer: RTL and testbench

Downstream of the 1536-strip first-8 cluster finder. Takes the eight latched (address, count) clusters for one bunch crossing and serializes them onto a 28-bit per-`clock4x` link word, two clusters per cycle over four cycles. Invalid and out-of-range clusters are sanitized to a fixed idle word. Alignment errors between the latch strobe and the frame cadence are detected, counted and recovered from.

---
 rtl/cluster_frame_serializer_if.sv | 35 +++
 rtl/cluster_frame_serializer.sv | 127 ++++++++++++
 tb/tb_cluster_frame_serializer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_frame_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : cluster_frame_serializer_if
// Brief    : Cluster capture inputs and 28-bit link-frame outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface cluster_frame_serializer_if;
    logic        latch_in;
    logic [10:0] adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7;
    logic [2:0]  cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7;
    logic [27:0] frame_out;
    logic        frame_valid;
    logic        frame_start;
    logic [1:0]  frame_phase;
    logic [3:0]  n_clusters;
    logic        adr_err;
    logic [7:0]  sync_err_cnt;

    modport master (
        output latch_in,
        output adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7,
        output cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7,
        input  frame_out, frame_valid, frame_start, frame_phase,
        input  n_clusters, adr_err, sync_err_cnt
    );

    modport slave (
        input  latch_in,
        input  adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7,
        input  cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7,
        output frame_out, frame_valid, frame_start, frame_phase,
        output n_clusters, adr_err, sync_err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cluster_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : cluster_frame_serializer
// Brief    : Serializes eight latched clusters into four 28-bit link words.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_frame_serializer #(
    parameter logic [10:0] INVALID_ADR = 11'h7FE,
    parameter int          MAX_ADR     = 1535
) (
    input  wire logic                  clock4x,
    input  wire logic                  global_reset,
    cluster_frame_serializer_if.slave  bus
);
    localparam logic [10:0] c_MAX_ADR   = 11'(MAX_ADR);
    localparam logic [13:0] c_IDLE_WORD = {3'd0, INVALID_ADR};

    logic [10:0] w_adr [8];
    logic [2:0]  w_cnt [8];
    logic [13:0] w_word [8];
    logic [7:0]  w_valid;
    logic [7:0]  w_bad;
    logic [3:0]  w_n_clusters;
    logic [27:0] w_next_pair;
    logic [1:0]  w_next_phase;
    logic        w_sync_err;

    logic        r_busy;
    logic [1:0]  r_phase;
    logic [27:0] r_pair1, r_pair2, r_pair3;
    logic [27:0] r_frame_out;
    logic        r_frame_valid;
    logic        r_frame_start;
    logic [3:0]  r_n_clusters;
    logic        r_adr_err;
    logic [7:0]  r_sync_err_cnt;

    always_comb begin
        w_adr[0] = bus.adr0; w_adr[1] = bus.adr1; w_adr[2] = bus.adr2; w_adr[3] = bus.adr3;
        w_adr[4] = bus.adr4; w_adr[5] = bus.adr5; w_adr[6] = bus.adr6; w_adr[7] = bus.adr7;
        w_cnt[0] = bus.cnt0; w_cnt[1] = bus.cnt1; w_cnt[2] = bus.cnt2; w_cnt[3] = bus.cnt3;
        w_cnt[4] = bus.cnt4; w_cnt[5] = bus.cnt5; w_cnt[6] = bus.cnt6; w_cnt[7] = bus.cnt7;
    end

    // Out-of-range addresses other than the "no cluster" marker are errors.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sanitize
            assign w_valid[gi] = (w_adr[gi] <= c_MAX_ADR);
            assign w_bad[gi]   = !w_valid[gi] && (w_adr[gi] != INVALID_ADR);
            assign w_word[gi]  = w_valid[gi] ? {w_cnt[gi], w_adr[gi]} : c_IDLE_WORD;
        end
    endgenerate

    always_comb begin
        w_n_clusters = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_n_clusters = w_n_clusters + {3'd0, w_valid[i]};
        end
    end

    assign w_next_phase = r_phase + 2'd1;
    assign w_sync_err   = r_busy && (r_phase != 2'd3);

    always_comb begin
        w_next_pair = r_pair3;
        case (r_phase)
            2'd0:    w_next_pair = r_pair1;
            2'd1:    w_next_pair = r_pair2;
            default: w_next_pair = r_pair3;
        endcase
    end

    // Phase 0 goes straight from the inputs; only phases 1..3 need storage.
    always_ff @(posedge clock4x) begin
        if (bus.latch_in && !global_reset) begin
            r_pair1 <= {w_word[3], w_word[2]};
            r_pair2 <= {w_word[5], w_word[4]};
            r_pair3 <= {w_word[7], w_word[6]};
        end
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            r_busy         <= 1'b0;
            r_phase        <= 2'd0;
            r_frame_out    <= {c_IDLE_WORD, c_IDLE_WORD};
            r_frame_valid  <= 1'b0;
            r_frame_start  <= 1'b0;
            r_n_clusters   <= 4'd0;
            r_adr_err      <= 1'b0;
            r_sync_err_cnt <= 8'd0;
        end else if (bus.latch_in) begin
            r_busy        <= 1'b1;
            r_phase       <= 2'd0;
            r_frame_out   <= {w_word[1], w_word[0]};
            r_frame_valid <= 1'b1;
            r_frame_start <= 1'b1;
            r_n_clusters  <= w_n_clusters;
            r_adr_err     <= |w_bad;
            if (w_sync_err && (r_sync_err_cnt != 8'hFF)) begin
                r_sync_err_cnt <= r_sync_err_cnt + 8'd1;
            end
        end else if (r_busy && (r_phase != 2'd3)) begin
            r_phase       <= w_next_phase;
            r_frame_out   <= w_next_pair;
            r_frame_start <= 1'b0;
            r_adr_err     <= 1'b0;
        end else begin
            r_busy        <= 1'b0;
            r_phase       <= 2'd0;
            r_frame_out   <= {c_IDLE_WORD, c_IDLE_WORD};
            r_frame_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_n_clusters  <= 4'd0;
            r_adr_err     <= 1'b0;
        end
    end

    assign bus.frame_out    = r_frame_out;
    assign bus.frame_valid  = r_frame_valid;
    assign bus.frame_start  = r_frame_start;
    assign bus.frame_phase  = r_phase;
    assign bus.n_clusters   = r_n_clusters;
    assign bus.adr_err      = r_adr_err;
    assign bus.sync_err_cnt = r_sync_err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_cluster_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_frame_serializer
// Brief    : Randomized plan-driven bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_frame_serializer;
    localparam int          MAXC = 400;
    localparam logic [13:0] IDLE = 14'h07FE;

    logic clock4x = 1'b0;
    logic global_reset;
    cluster_frame_serializer_if bus ();

    cluster_frame_serializer #(.INVALID_ADR(11'h7FE), .MAX_ADR(1535)) dut (
        .clock4x      (clock4x),
        .global_reset (global_reset),
        .bus          (bus.slave)
    );

    always #5 clock4x = ~clock4x;

    wire [44:0] obs = {bus.frame_out, bus.frame_valid, bus.frame_start, bus.frame_phase,
                       bus.n_clusters, bus.adr_err, bus.sync_err_cnt};

    int total = 0;
    int bad   = 0;

    // Stimulus plan, one entry per cycle
    bit          p_lat [MAXC];
    bit          p_rst [MAXC];
    logic [10:0] p_adr [MAXC][8];
    logic [2:0]  p_cnt [MAXC][8];

    // Reference model state: most recent accepted latch and its frame content
    int          last_lat;
    logic [13:0] f_w [8];
    int          f_n;
    bit          f_err;
    logic [7:0]  exp_sync;
    logic [44:0] exp_vec;

    function automatic logic [10:0] rand_adr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2)  return 11'h7FE;
        if (r == 2) return 11'($urandom_range(1536, 2047));
        return 11'($urandom_range(0, 1535));
    endfunction

    task automatic begin_plan(input int n);
        for (int c = 0; c < n; c++) begin
            p_lat[c] = 1'b0;
            p_rst[c] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                p_adr[c][i] = rand_adr();
                p_cnt[c][i] = 3'($urandom_range(0, 7));
            end
        end
        last_lat = -100;
    endtask

    // Drive cycle c, predict outputs after its clock edge, then settle.
    task automatic step(input int c);
        int k;
        @(negedge clock4x);
        global_reset = p_rst[c];
        bus.latch_in = p_lat[c];
        bus.adr0 = p_adr[c][0]; bus.adr1 = p_adr[c][1]; bus.adr2 = p_adr[c][2]; bus.adr3 = p_adr[c][3];
        bus.adr4 = p_adr[c][4]; bus.adr5 = p_adr[c][5]; bus.adr6 = p_adr[c][6]; bus.adr7 = p_adr[c][7];
        bus.cnt0 = p_cnt[c][0]; bus.cnt1 = p_cnt[c][1]; bus.cnt2 = p_cnt[c][2]; bus.cnt3 = p_cnt[c][3];
        bus.cnt4 = p_cnt[c][4]; bus.cnt5 = p_cnt[c][5]; bus.cnt6 = p_cnt[c][6]; bus.cnt7 = p_cnt[c][7];
        if (p_rst[c]) begin
            last_lat = -100;
            exp_sync = 8'd0;
        end else if (p_lat[c]) begin
            if ((c - last_lat) >= 1 && (c - last_lat) <= 3 && exp_sync != 8'hFF) exp_sync++;
            last_lat = c;
            f_n   = 0;
            f_err = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (p_adr[c][i] <= 11'd1535) begin
                    f_w[i] = {p_cnt[c][i], p_adr[c][i]};
                    f_n++;
                end else begin
                    f_w[i] = IDLE;
                    if (p_adr[c][i] != 11'h7FE) f_err = 1'b1;
                end
            end
        end
        k = c - last_lat;
        if (k >= 0 && k <= 3)
            exp_vec = {f_w[2*k+1], f_w[2*k], 1'b1, (k == 0), 2'(k), 4'(f_n), (k == 0) && f_err, exp_sync};
        else
            exp_vec = {IDLE, IDLE, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, exp_sync};
        @(posedge clock4x);
        #1;
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        bus.latch_in = 1'b1;
        repeat (3) @(posedge clock4x);
        #1;
        total++;
        if (obs !== {IDLE, IDLE, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset got=%h want=%h", obs, {IDLE, IDLE, 17'd0});
        end
        exp_sync = 8'd0;
        last_lat = -100;
    endtask

    task automatic test_single_frame();
        begin_plan(12);
        p_lat[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p_adr[2][i] = 11'(i * 100);
            p_cnt[2][i] = 3'(i + 1);
        end
        for (int c = 0; c < 12; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL single c=%0d got=%h want=%h", c, obs, exp_vec);
            end
            if (c == 2) begin
                total++;
                if (bus.frame_out !== {3'd2, 11'd100, 3'd1, 11'd0} || bus.n_clusters !== 4'd8) begin
                    bad++;
                    $display("FAIL single_phase0 got=%h/%0d want=%h/8", bus.frame_out, bus.n_clusters,
                             {3'd2, 11'd100, 3'd1, 11'd0});
                end
            end
        end
    endtask

    task automatic test_partial();
        begin_plan(10);
        p_lat[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p_adr[2][i] = 11'h7FE;
            p_cnt[2][i] = 3'd7;
        end
        p_adr[2][0] = 11'd5;
        p_cnt[2][0] = 3'd3;
        for (int c = 0; c < 10; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL partial c=%0d got=%h want=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_out_of_range();
        begin_plan(10);
        p_lat[2] = 1'b1;
        for (int i = 0; i < 8; i++) p_adr[2][i] = 11'($urandom_range(0, 1535));
        p_adr[2][3] = 11'd1600;
        for (int c = 0; c < 10; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL out_of_range c=%0d got=%h want=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        begin_plan(50);
        for (int i = 0; i < 10; i++) p_lat[2 + 4*i] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL back_to_back c=%0d got=%h want=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_misalign();
        begin_plan(14);
        p_lat[2] = 1'b1;
        p_lat[4] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL misalign c=%0d got=%h want=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        begin_plan(300);
        for (int c = 0; c < 290; c++) begin
            p_lat[c] = ($urandom_range(0, 2) == 0);
            p_rst[c] = ($urandom_range(0, 59) == 0);
        end
        for (int c = 0; c < 300; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_saturate();
        begin_plan(320);
        for (int c = 2; c < 312; c++) p_lat[c] = 1'b1;
        for (int c = 0; c < 320; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL saturate c=%0d got=%h want=%h", c, obs, exp_vec);
            end
        end
        total++;
        if (bus.sync_err_cnt !== 8'hFF) begin
            bad++;
            $display("FAIL saturate_cnt got=%0d want=255", bus.sync_err_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        begin_plan(12);
        p_lat[2] = 1'b1;
        p_rst[4] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL reset_midframe c=%0d got=%h want=%h", c, obs, exp_vec);
            end
        end
    endtask

    task automatic test_reset_with_latch();
        begin_plan(16);
        p_lat[2] = 1'b1;
        p_lat[3] = 1'b1;
        p_lat[9] = 1'b1;
        p_rst[9] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step(c);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL reset_with_latch c=%0d got=%h want=%h", c, obs, exp_vec);
            end
        end
    endtask

    initial begin
        global_reset = 1'b1;
        bus.latch_in = 1'b0;
        bus.adr0 = 11'h7FE; bus.adr1 = 11'h7FE; bus.adr2 = 11'h7FE; bus.adr3 = 11'h7FE;
        bus.adr4 = 11'h7FE; bus.adr5 = 11'h7FE; bus.adr6 = 11'h7FE; bus.adr7 = 11'h7FE;
        bus.cnt0 = 3'd0; bus.cnt1 = 3'd0; bus.cnt2 = 3'd0; bus.cnt3 = 3'd0;
        bus.cnt4 = 3'd0; bus.cnt5 = 3'd0; bus.cnt6 = 3'd0; bus.cnt7 = 3'd0;
        exp_sync = 8'd0;
        last_lat = -100;
        f_n      = 0;
        f_err    = 1'b0;
        for (int i = 0; i < 8; i++) f_w[i] = IDLE;

        test_reset();
        test_single_frame();
        test_partial();
        test_out_of_range();
        test_back_to_back();
        test_misalign();
        test_random();
        test_saturate();
        test_reset_midframe();
        test_reset_with_latch();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
